hilo_div_unit: RTL
==================

Name: hilo_div_unit

Overview:
- Multi-cycle HI/LO divide unit that services the divide request and HI-move selection produced by the instruction-decode control unit.
- On a divide request it performs a WIDTH-iteration restoring division and writes the quotient to LO and the remainder to HI.
- While the division runs it drives a stall to the pipeline.
- It also serves mfhi/mflo reads and mthi/mtlo writes on the HI/LO pair.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- main_clock  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  divide request (decoded div/divu, instruction valid); sampled only in IDLE.
- signed_op  in  1  1 = div (two's complement), 0 = divu; sampled with start.
- dividend  in  WIDTH  rs operand; sampled with start.
- divisor  in  WIDTH  rt operand; sampled with start.
- mt_hi  in  1  write dividend value into HI (mthi); honoured only in IDLE or DONE with start low.
- mt_lo  in  1  write dividend value into LO (mtlo); same rule as mt_hi.
- rd_sel  in  1  1 = read HI (mfhi), 0 = read LO (mflo).
- rd_data  out  WIDTH  combinational: rd_sel ? hi_q : lo_q.
- stall  out  1  pipeline hold request.
- done  out  1  one-cycle pulse; new HI/LO are valid in this cycle.
- div_zero  out  1  set at completion of a divide with divisor == 0; cleared when the next start is accepted.

Behaviour:
Reset:
- reset_n low immediately (asynchronously) forces IDLE.
- hi_q = 0, lo_q = 0, counter = 0, done = 0, div_zero = 0, stall = 0.
- Applies equally in the middle of CALC or FIX; the partial result is discarded and HI/LO are cleared.

State machine: IDLE, CALC, FIX, DONE.
- IDLE:
  - start = 1 → latch |dividend|, |divisor| and the sign flags (magnitudes only when signed_op = 1).
  - Clear the remainder accumulator, set counter = WIDTH, clear div_zero, go to CALC.
  - stall = start, combinational in the start cycle.
- CALC, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from rem using a WIDTH+1-bit subtract.
  - If the result is non-negative, keep it and set the quotient LSB.
  - Decrement counter; at counter = 1 go to FIX.
  - stall = 1.
- FIX:
  - Negate the quotient if the dividend and divisor signs differ.
  - Negate the remainder if the dividend is negative (the remainder takes the dividend's sign).
  - Register the results into lo_q and hi_q on this edge.
  - Set div_zero if the divisor was 0; go to DONE.
  - stall = 1.
- DONE: done = 1, stall = 0, go to IDLE.
  - A start in DONE is ignored; the issuing stage re-presents it in IDLE.

Latency:
- Start cycle = cycle 0; CALC occupies cycles 1..WIDTH; FIX is cycle WIDTH+1; DONE is cycle WIDTH+2.
- stall is high in cycles 0..WIDTH+1.

Divide by zero:
- No trap; full latency is still taken.
- The natural algorithm result is forced to lo = all ones and hi = dividend (raw input value).

Signed overflow:
- 0x80000000 / -1 (signed) gives lo = 0x80000000, hi = 0; this falls out of magnitude arithmetic with wrap.

Other rules:
- start while in CALC or FIX has no effect: no restart, operands are not re-latched.
- mt_hi/mt_lo are ignored in CALC and FIX.
- When mt_hi/mt_lo and start are asserted together in IDLE, start wins and the mt write is dropped.
- mt_hi and mt_lo together write the same value into both registers.
- rd_data reflects register contents only; during CALC/FIX it shows the old HI/LO.

Test Plan:
- Unsigned 100 / 7 (divu), start at cycle 0 → stall high cycles 0..33, done at cycle 34; rd_sel = 0 gives 14, rd_sel = 1 gives 2; div_zero = 0.
- Signed -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Signed 7 / -2 → lo = 0xFFFFFFFD, hi = 1.
- Divide by zero: divu 5 / 0 → lo = 0xFFFFFFFF, hi = 5, div_zero = 1 at done. A following divu 9 / 3 clears div_zero at its start: lo = 3, hi = 0.
- Overflow and re-issue:
  - Signed 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
  - start pulsed again at cycle 10 with different operands → ignored; done still at cycle 34 with the original result.
- Reset mid-CALC: at cycle 15 of a division with HI/LO preloaded by mthi/mtlo to 0xAA/0xBB, pulse reset_n low → state IDLE, stall = 0, hi = lo = 0, no done pulse. The next start completes normally.
- Moves: in IDLE, mt_hi with 0x1234 → rd_sel = 1 reads 0x1234. mt_lo asserted with start → LO ends up holding the quotient, not the mt value.

Source files
------------

// File: rtl/hilo_div_unit_if.sv
// rtl/hilo_div_unit_if.sv - request/response bundle between decode control and the HI/LO divide unit
interface hilo_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             mt_hi;
  logic             mt_lo;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             stall;
  logic             done;
  logic             div_zero;

  modport master (
    output start, signed_op, dividend, divisor, mt_hi, mt_lo, rd_sel,
    input  rd_data, stall, done, div_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor, mt_hi, mt_lo, rd_sel,
    output rd_data, stall, done, div_zero
  );
endinterface

// File: rtl/hilo_div_unit.sv
// rtl/hilo_div_unit.sv - multi-cycle restoring divider with HI/LO register pair and move ports
module hilo_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic             main_clock,
  input logic             reset_n,
  hilo_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;          // divisor magnitude
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;  // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d;        // quotient must be negated in FIX
  logic             rneg_q, rneg_d;        // remainder takes the dividend's sign
  logic             dz_q, dz_d;            // latched divisor == 0
  logic             div_zero_q, div_zero_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   trial_ext;
  logic [WIDTH+1:0] trial_diff;
  logic             mt_ok;
  logic             stall_o, done_o;

  // Sign/magnitude decode of the operands presented in the start cycle
  always_comb begin
    dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
    dvs_neg = bus.signed_op & bus.divisor[WIDTH-1];
    dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
    dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;
  end

  // One restoring step: shift {rem, quo} left and trial-subtract; borrow bit gives the sign
  always_comb begin
    trial_ext  = {rem_q, quo_q[WIDTH-1]};
    trial_diff = {1'b0, trial_ext} - {2'b00, dvs_q};
  end

  // Next-state, datapath updates and pipeline-facing outputs
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    dvd_raw_d  = dvd_raw_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    div_zero_d = div_zero_q;
    mt_ok      = 1'b0;
    stall_o    = 1'b0;
    done_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = CALC;
          rem_d      = '0;
          quo_d      = dvd_mag;
          dvs_d      = dvs_mag;
          dvd_raw_d  = bus.dividend;
          qneg_d     = dvd_neg ^ dvs_neg;
          rneg_d     = dvd_neg;
          dz_d       = (bus.divisor == '0);
          cnt_d      = CNT_W'(WIDTH);
          div_zero_d = 1'b0;
          stall_o    = 1'b1;
        end else begin
          mt_ok = 1'b1;
        end
      end

      CALC: begin
        stall_o = 1'b1;
        if (!trial_diff[WIDTH+1]) begin
          rem_d = trial_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial_ext[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        stall_o    = 1'b1;
        lo_d       = dz_q ? '1        : (qneg_q ? -quo_q : quo_q);
        hi_d       = dz_q ? dvd_raw_q : (rneg_q ? -rem_q : rem_q);
        div_zero_d = dz_q;
        state_d    = DONE;
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
        mt_ok   = !bus.start;
      end

      default: state_d = IDLE;
    endcase

    // Moves only land when no divide is being started or running
    if (mt_ok) begin
      if (bus.mt_hi) hi_d = bus.dividend;
      if (bus.mt_lo) lo_d = bus.dividend;
    end
  end

  assign bus.stall    = stall_o;
  assign bus.done     = done_o;
  assign bus.div_zero = div_zero_q;
  assign bus.rd_data  = bus.rd_sel ? hi_q : lo_q;

  // State and datapath registers; reset discards any division in flight
  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_raw_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      dvd_raw_q  <= dvd_raw_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule
